if_fetch_queue: RTL and testbench



---
 rtl/if_fetch_queue_pkg.sv | 28 ++
 rtl/if_fetch_queue_fetch_entry_queue.sv | 85 ++++++++
 rtl/if_fetch_queue.sv | 128 ++++++++++++
 tb/tb_if_fetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch constants, entry tag type and the fixed VA->PA mapping.
// Also used by the data-side fetch for address translation.
package if_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          PC_W             = 32;
    localparam int          EXCCODE_W        = 8;
    localparam logic [EXCCODE_W-1:0] EXC_ADEL = 8'h04;
    localparam logic [EXCCODE_W-1:0] EXC_NONE = 8'h00;
    localparam logic [1:0]  KSEG_SEL         = 2'b10;
    localparam logic [31:0] KSEG_MASK        = 32'h1FFF_FFFF;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            exc;
    } fq_tag_t;

    // kseg0/kseg1 drop the segment bits; every other segment is identity.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        if (va[31:30] == KSEG_SEL) begin
            pa = va & KSEG_MASK;
        end
        return pa;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_entry_queue.sv
// In-order fetch entry storage: allocate at issue, fill on response,
// pop at the head; flush drops everything.
module fetch_entry_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   alloc_i,
    input  fq_tag_t                alloc_tag_i,
    input  logic                   fill_i,
    input  logic [DATA_W-1:0]      fill_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] unfilled_o,
    output fq_tag_t                head_tag_o,
    output logic [DATA_W-1:0]      head_inst_o,
    output logic                   head_filled_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_tag_t           tag_q  [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [PW-1:0]     fill_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     unfilled_q;
    logic              fill_ok;
    logic              alloc_req;

    assign fill_ok   = fill_i && (unfilled_q != '0);
    assign alloc_req = alloc_i && !alloc_tag_i.exc;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            filled_q   <= '0;
        end else begin
            if (alloc_i) begin
                tail_q           <= tail_q + PW'(1);
                filled_q[tail_q] <= alloc_tag_i.exc;
            end
            if (fill_ok) begin
                fill_q           <= fill_q + PW'(1);
                filled_q[fill_q] <= 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
            unfilled_q <= unfilled_q + CW'(alloc_req) - CW'(fill_ok);
        end
    end

    // Exception entries are born filled with a zero instruction.
    always_ff @(posedge clk) begin
        if (alloc_i) begin
            tag_q[tail_q] <= alloc_tag_i;
            if (alloc_tag_i.exc) begin
                inst_q[tail_q] <= '0;
            end
        end
        if (fill_ok) begin
            inst_q[fill_q] <= fill_data_i;
        end
    end

    assign count_o       = count_q;
    assign unfilled_o    = unfilled_q;
    assign head_tag_o    = tag_q[head_q];
    assign head_inst_o   = inst_q[head_q];
    assign head_filled_o = filled_q[head_q];

endmodule

// File: rtl/if_fetch_queue.sv
// Pipelined instruction fetch with an in-order response queue,
// redirect flush with stale-response discard, and AdEL on misaligned PC.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [DATA_W-1:0]    if_inst,
    output logic                 if_exc,
    output logic [EXCCODE_W-1:0] if_exccode,
    output logic                 inst_req,
    output logic [31:0]          inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    input  logic [DATA_W-1:0]    inst_rdata
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              halted_q, halted_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW-1:0]     count;
    logic [CW-1:0]     unfilled;
    fq_tag_t           head_tag;
    fq_tag_t           alloc_tag;
    logic [DATA_W-1:0] head_inst;
    logic              head_filled;

    logic room, aligned, hs, mis, alloc, drop, fill, pop;

    assign room    = rst_n && !halted_q && !redirect_valid
                   && (count < DEPTH_C);
    assign aligned = (fetch_pc_q[1:0] == 2'b00);

    assign inst_req  = room && aligned;
    assign inst_addr = map_addr(fetch_pc_q);

    assign hs    = inst_req && inst_addr_ok;
    assign mis   = room && !aligned;
    assign alloc = hs || mis;

    assign alloc_tag = '{pc: fetch_pc_q, exc: mis};

    assign drop = inst_data_ok && (discard_q != '0);
    assign fill = inst_data_ok && !drop && !redirect_valid;

    assign if_valid = head_filled && (count != '0) && !redirect_valid;
    assign pop      = if_valid && id_ready;

    fetch_entry_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (redirect_valid),
        .alloc_i       (alloc),
        .alloc_tag_i   (alloc_tag),
        .fill_i        (fill),
        .fill_data_i   (inst_rdata),
        .pop_i         (pop),
        .count_o       (count),
        .unfilled_o    (unfilled),
        .head_tag_o    (head_tag),
        .head_inst_o   (head_inst),
        .head_filled_o (head_filled)
    );

    // Every unfilled request still owes one response that must be dropped.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            discard_d  = discard_q + unfilled - CW'(inst_data_ok);
        end else begin
            if (hs) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (mis) begin
                halted_d = 1'b1;
            end
            if (drop) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            discard_q  <= discard_d;
        end
    end

    assign if_pc      = if_valid ? head_tag.pc : 32'h0;
    assign if_exc     = if_valid && head_tag.exc;
    assign if_inst    = (if_valid && !head_tag.exc) ? head_inst : '0;
    assign if_exccode = if_exc ? EXC_ADEL : EXC_NONE;

    a_resp_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        inst_data_ok |-> (discard_q != '0 || unfilled != '0));

    a_discard_bound: assert property (
        @(posedge clk) disable iff (!rst_n)
        discard_q <= DEPTH_C);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed scoreboard bench for if_fetch_queue with an in-order
// one-cycle-latency memory model.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_exc;
    logic [7:0]  if_exccode;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'hBFC0_0000),
        .DATA_W   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_exc         (if_exc),
        .if_exccode     (if_exccode),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [7:0]  code;
    } exp_t;

    exp_t        exp_q   [$];
    logic [31:0] mem_q   [$];
    logic [31:0] hs_addr [$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int req_cnt = 0;
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;

    logic        rv = 1'b0;
    logic        idr = 1'b0;
    logic        aok = 1'b0;
    logic        hold = 1'b0;
    logic        rst_t = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        last_req = 1'b0;

    function automatic logic [31:0] rd(input logic [31:0] pa);
        return pa ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst,
                            input logic exc, input logic [7:0] code);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.exc  = exc;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (!rst_t) mem_q.delete();
        if (!hold && mem_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = rd(mem_q.pop_front());
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
        end
        rst_n          = rst_t;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = idr;
        inst_addr_ok   = aok;
        #1;
        last_req = inst_req;
        if (inst_req) req_cnt++;
        if (inst_req && inst_addr_ok) begin
            hs_cnt++;
            mem_q.push_back(inst_addr);
            hs_addr.push_back(inst_addr);
        end
    endtask

    task automatic do_reset();
        rst_t = 1'b0;
        rv    = 1'b0;
        idr   = 1'b0;
        aok   = 1'b0;
        hold  = 1'b0;
        repeat (3) cycle();
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_inst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_exc", {31'h0, if_exc}, 32'h0);
        chk("rst_if_exccode", {24'h0, if_exccode}, 32'h0);
        rst_t   = 1'b1;
        hs_cnt  = 0;
        req_cnt = 0;
        pops    = 0;
        hs_addr.delete();
    endtask

    task automatic run_hs(input int n, input string name);
        int budget;
        budget = 0;
        aok = 1'b1;
        while (hs_cnt < n && budget < 40) begin
            cycle();
            budget++;
        end
        aok = 1'b0;
        chk(name, hs_cnt, n);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 60) begin
            cycle();
            budget++;
        end
        repeat (4) cycle();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        rv  = 1'b1;
        rpc = pc;
        cycle();
        rv  = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                if (redirect_valid) begin
                    n_vec++;
                    if (if_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL valid_in_redirect: got %b want 0",
                                 if_valid);
                    end
                end
                if (if_valid && id_ready) begin
                    pops++;
                    if (pops == 1) first_pop = cyc;
                    last_pop = cyc;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_delivery: got pc %h want none",
                                 if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (if_pc !== e.pc || if_inst !== e.inst ||
                            if_exc !== e.exc || if_exccode !== e.code) begin
                            n_bad++;
                            $display("FAIL delivery: got pc %h inst %h exc %b code %h want pc %h inst %h exc %b code %h",
                                     if_pc, if_inst, if_exc, if_exccode,
                                     e.pc, e.inst, e.exc, e.code);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'h0;

        // Streaming from the reset vector.
        do_reset();
        idr = 1'b1;
        for (int i = 0; i < 8; i++)
            push_exp(32'hBFC0_0000 + 32'(4*i), rd(32'h1FC0_0000 + 32'(4*i)),
                     1'b0, 8'h00);
        run_hs(8, "stream_hs");
        drain("stream_drain");
        for (int i = 0; i < 8; i++)
            chk("stream_addr", hs_addr[i], 32'h1FC0_0000 + 32'(4*i));
        chk("stream_pops", pops, 8);
        chk("stream_gapless", last_pop - first_pop, 7);

        // Back-pressure fills the queue, then resumes.
        do_reset();
        idr = 1'b0;
        aok = 1'b1;
        repeat (10) cycle();
        aok = 1'b0;
        chk("bp_hs", hs_cnt, 4);
        chk("bp_req_low", {31'h0, last_req}, 32'h0);
        for (int i = 0; i < 8; i++)
            push_exp(32'hBFC0_0000 + 32'(4*i), rd(32'h1FC0_0000 + 32'(4*i)),
                     1'b0, 8'h00);
        idr = 1'b1;
        run_hs(8, "bp_resume_hs");
        chk("bp_resume_addr", hs_addr[4], 32'h1FC0_0010);
        drain("bp_drain");

        // Redirect with 3 in flight, 1 filled, 2 unfilled.
        do_reset();
        idr  = 1'b0;
        hold = 1'b1;
        run_hs(3, "rd_hs");
        hold = 1'b0;
        cycle();
        hold = 1'b1;
        redirect(32'h8000_1000);
        hold = 1'b0;
        idr  = 1'b1;
        for (int i = 0; i < 3; i++)
            push_exp(32'h8000_1000 + 32'(4*i), rd(32'h0000_1000 + 32'(4*i)),
                     1'b0, 8'h00);
        run_hs(6, "rd_new_hs");
        drain("rd_drain");
        chk("rd_first_addr", hs_addr[3], 32'h0000_1000);
        chk("rd_pops", pops, 3);

        // Redirect coinciding with a response and a would-be pop.
        do_reset();
        idr  = 1'b0;
        hold = 1'b1;
        run_hs(3, "rdp_hs");
        hold = 1'b0;
        cycle();
        hold = 1'b1;
        hold = 1'b0;
        idr  = 1'b1;
        redirect(32'h8000_2000);
        for (int i = 0; i < 2; i++)
            push_exp(32'h8000_2000 + 32'(4*i), rd(32'h0000_2000 + 32'(4*i)),
                     1'b0, 8'h00);
        run_hs(5, "rdp_new_hs");
        drain("rdp_drain");
        chk("rdp_pops", pops, 2);

        // Misaligned redirect raises AdEL and halts.
        do_reset();
        redirect(32'h8000_0002);
        push_exp(32'h8000_0002, 32'h0, 1'b1, 8'h04);
        idr = 1'b1;
        aok = 1'b1;
        repeat (8) cycle();
        chk("mis_no_req", req_cnt, 0);
        chk("mis_pops", pops, 1);
        chk("mis_exp_empty", exp_q.size(), 0);
        redirect(32'h8000_0100);
        push_exp(32'h8000_0100, rd(32'h0000_0100), 1'b0, 8'h00);
        push_exp(32'h8000_0104, rd(32'h0000_0104), 1'b0, 8'h00);
        run_hs(2, "mis_resume_hs");
        drain("mis_drain");
        chk("mis_resume_addr", hs_addr[0], 32'h0000_0100);

        // Fetch wraps across the top of the address space.
        do_reset();
        idr = 1'b1;
        redirect(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFF8, rd(32'hFFFF_FFF8), 1'b0, 8'h00);
        push_exp(32'hFFFF_FFFC, rd(32'hFFFF_FFFC), 1'b0, 8'h00);
        push_exp(32'h0000_0000, rd(32'h0000_0000), 1'b0, 8'h00);
        run_hs(3, "wrap_hs");
        drain("wrap_drain");
        chk("wrap_addr_top", hs_addr[1], 32'hFFFF_FFFC);
        chk("wrap_addr_zero", hs_addr[2], 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
